// File: rtl/tmcu_sram_pkg.sv
// Shared types and default parameter values for the TMCU SRAM controller.
package tmcu_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH       = 1024;
  localparam int DEF_WAIT_STATES = 0;
  localparam int DEF_ADDR_W      = 32;

endpackage

// File: rtl/tmcu_sram_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
module tmcu_sram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int NB    = DATA_W / 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [NB-1:0]     we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write word; the controller masks read data on writes.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < NB; b++) begin
        if (we[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/tmcu_sram_ctrl.sv
// Single-outstanding request/response SRAM controller with programmable wait states.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// the sender holds its fields stable while valid=1 and ready=0.
module tmcu_sram_ctrl
  import tmcu_sram_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int ADDR_W      = DEF_ADDR_W,
  localparam int NB         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NB-1:0]     req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output state_t            dbg_state
);

  localparam int OFF_W = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LIM   = IDX_W + OFF_W;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              live_q;
  logic              wr_q, err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;

  logic              accept, addr_err, arr_en, sel_live;
  logic              a_write, a_err;
  logic [IDX_W-1:0]  a_idx, req_idx;
  logic [DATA_W-1:0] a_wdata, arr_rdata;
  logic [NB-1:0]     a_be, a_we;

  // live_q keeps req_ready low until the first edge after reset release.
  assign req_ready = live_q && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign addr_err  = (req_addr >> LIM) != '0;
  assign req_idx   = req_addr[LIM-1:OFF_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arr_en   = 1'b0;
    sel_live = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d  = ST_RESP;
            arr_en   = 1'b1;
            sel_live = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          arr_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the array is accessed on the accepting edge itself,
  // so the live request fields feed it directly.
  always_comb begin
    a_write = sel_live ? req_write : wr_q;
    a_err   = sel_live ? addr_err  : err_q;
    a_idx   = sel_live ? req_idx   : idx_q;
    a_wdata = sel_live ? req_wdata : wdata_q;
    a_be    = sel_live ? req_be    : be_q;
    a_we    = a_be & {NB{arr_en && a_write && !a_err}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      live_q  <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= addr_err;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  tmcu_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (a_we),
    .idx   (a_idx),
    .wdata (a_wdata),
    .rdata (arr_rdata)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !wr_q) ? arr_rdata : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tmcu_sram_ctrl.sv
// Directed bench for tmcu_sram_ctrl: three instances with 0, 3 and 2 wait states.
module tb_tmcu_sram_ctrl;
  import tmcu_sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  state_t      dbg_state [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    tmcu_sram_ctrl #(
      .DATA_W      (32),
      .DEPTH       (1024),
      .WAIT_STATES (WS),
      .ADDR_W      (32)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .dbg_state (dbg_state[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance d; hold = extra cycles of rsp_ready=0 in RESP.
  task automatic do_xact(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int exp_lat, input int hold,
                         output logic [31:0] rdata, output logic err);
    int n;
    int cyc;
    logic ok;
    logic [31:0] held;
    @(negedge clk);
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_write[d] = ~wr;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom);
    cyc = 0;
    ok  = 1'b1;
    @(negedge clk);
    while (!rsp_valid[d] && cyc < 40) begin
      if (req_ready[d]) ok = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (req_ready[d]) ok = 1'b0;
    check("latency", 32'(cyc + 1), 32'(exp_lat));
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    held  = rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid[d] || rsp_rdata[d] !== held || rsp_err[d] !== err || req_ready[d]) ok = 1'b0;
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    check("post_handshake", {30'd0, rsp_valid[d], req_ready[d]}, 32'b01);
    check("ready_low_stable", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    bit          quiet;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_be[i]    = '0;
      rsp_ready[i] = 1'b0;
    end

    // Reset values
    #1;
    check("rst_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_ready", 32'(req_ready[0]), 32'd0);
    check("rst_rdata", rsp_rdata[0], 32'd0);
    check("rst_state", 32'(dbg_state[0]), 32'(ST_IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst0", 32'(req_ready[0]), 32'd1);
    check("ready_after_rst1", 32'(req_ready[1]), 32'd1);

    // Zero wait states: write then read, low offset bits ignored
    do_xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, rd, er);
    check("wr10_rdata", rd, 32'd0);
    check("wr10_err", 32'(er), 32'd0);
    do_xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, 0, rd, er);
    check("rd10_rdata", rd, 32'hDEADBEEF);
    check("rd10_err", 32'(er), 32'd0);
    do_xact(0, 1'b0, 32'h13, 32'h0, 4'h0, 1, 0, rd, er);
    check("rd13_rdata", rd, 32'hDEADBEEF);

    // Byte enables and be=0 no-op
    do_xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1, 0, rd, er);
    do_xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1, 0, rd, er);
    do_xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 1, 0, rd, er);
    check("rd20_be5", rd, 32'h11BB33DD);
    do_xact(0, 1'b1, 32'h20, 32'h00000000, 4'h0, 1, 0, rd, er);
    check("wr20_be0_err", 32'(er), 32'd0);
    do_xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 1, 0, rd, er);
    check("rd20_be0", rd, 32'h11BB33DD);

    // Out of range: 0x1000 aliases word 0 if the range check is missing
    do_xact(0, 1'b1, 32'h0, 32'hCAFE0000, 4'hF, 1, 0, rd, er);
    do_xact(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, 1, 0, rd, er);
    check("oor_wr_err", 32'(er), 32'd1);
    check("oor_wr_rdata", rd, 32'd0);
    do_xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 0, rd, er);
    check("rd0_after_oor", rd, 32'hCAFE0000);
    check("rd0_err", 32'(er), 32'd0);
    do_xact(0, 1'b0, 32'h2000, 32'h0, 4'h0, 1, 0, rd, er);
    check("oor_rd_err", 32'(er), 32'd1);
    check("oor_rd_rdata", rd, 32'd0);

    // Backpressure for 5 cycles
    do_xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, 5, rd, er);
    check("bp_rdata", rd, 32'hDEADBEEF);

    // Three wait states; inputs scrambled after accept must not matter
    do_xact(1, 1'b1, 32'h30, 32'h0F0F0F0F, 4'hF, 4, 0, rd, er);
    check("ws3_wr_err", 32'(er), 32'd0);
    do_xact(1, 1'b0, 32'h30, 32'h0, 4'h0, 4, 2, rd, er);
    check("ws3_rd_rdata", rd, 32'h0F0F0F0F);

    // Two wait states: reset in the middle of a write
    do_xact(2, 1'b1, 32'h40, 32'h12345678, 4'hF, 3, 0, rd, er);
    @(negedge clk);
    req_write[2] = 1'b1;
    req_addr[2]  = 32'h40;
    req_wdata[2] = 32'hFFFFFFFF;
    req_be[2]    = 4'hF;
    req_valid[2] = 1'b1;
    check("ws2_ready", 32'(req_ready[2]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("ws2_in_wait", 32'(dbg_state[2]), 32'(ST_WAIT));
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(dbg_state[2]), 32'(ST_IDLE));
    check("midrst_valid", 32'(rsp_valid[2]), 32'd0);
    check("midrst_err_rdata", {rsp_err[2], rsp_rdata[2][30:0]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid[2]) quiet = 1'b0;
    end
    check("midrst_no_rsp", 32'(quiet), 32'd1);
    check("midrst_ready", 32'(req_ready[2]), 32'd1);
    do_xact(2, 1'b0, 32'h40, 32'h0, 4'h0, 3, 0, rd, er);
    check("rd40_old", rd, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmcu_sram_ctrl.md
TMCU_SRAM_CTRL -- requirements
Module: tmcu_sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024, number of words; SHALL be a power of two, minimum 16.
REQ-003 Parameter WAIT_STATES, default 0, extra cycles inserted between request accept and response; range 0..15.
REQ-004 Parameter ADDR_W, default 32, byte-address width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  controller can accept a request.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 req_be  input  DATA_W/8  byte enables for writes.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  requester accepts response.
REQ-015 rsp_rdata  output  DATA_W  read data; zero for writes and errors.
REQ-016 rsp_err  output  1  address out of range.

Function
REQ-017 Request accepted on a cycle with req_valid & req_ready; accepted fields SHALL be registered, and later input changes SHALL be ignored.
REQ-018 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE -> WAIT on accept when WAIT_STATES>0, loading the wait counter with WAIT_STATES-1; IDLE -> RESP on accept when WAIT_STATES=0.
REQ-020 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter equals 0.
REQ-021 Array access (read or write) SHALL occur on the edge that enters RESP, giving rsp_valid exactly WAIT_STATES+1 cycles after the accepting edge.
REQ-022 Word index = req_addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]; low byte-offset bits SHALL be ignored.
REQ-023 An address with any bit set at or above log2(DEPTH*DATA_W/8) SHALL give rsp_err=1 and rsp_rdata=0, with no array write.
REQ-024 A write SHALL update only the bytes whose req_be bit is 1; req_be=0 SHALL be a legal no-op that still responds.
REQ-025 In RESP, rsp_valid=1 and the rsp_* fields SHALL hold stable until rsp_ready=1; RESP -> IDLE on rsp_valid & rsp_ready.
REQ-026 No new request SHALL be accepted in the cycle the response handshakes; the earliest next accept is the following cycle, giving at most one outstanding request.
REQ-027 A read of a word written by the previous transaction SHALL return the new data.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately force state=IDLE, counter=0, rsp_valid=0, rsp_err=0 and rsp_rdata=0; req_ready SHALL be 1 from the first rising clock edge after release.
REQ-029 Reset in the middle of a transaction SHALL abandon that transaction with no response; a write not yet committed SHALL NOT modify the array.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 Package tmcu_sram_pkg SHALL hold the state enum type and the default parameter constants.
REQ-032 Storage SHALL be the sub-module tmcu_sram_array: DEPTH x DATA_W, synchronous per-byte write enable, registered read port, no reset.

Verification
REQ-033 WAIT_STATES=0: write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 -> rsp_valid 1 cycle after each accept, rdata=0xDEADBEEF, err=0.
REQ-034 Byte enables: write 0x11223344 to 0x20 with be=0xF, then 0xAABBCCDD with be=0x5, then read 0x20 -> 0x11BB33DD.
REQ-035 WAIT_STATES=3: read accepted at cycle N -> rsp_valid first at N+4, req_ready=0 during N+1..N+4.
REQ-036 Out of range: write to 0x1000 (DEPTH=1024) -> err=1, rdata=0; a later read of 0x0 returns the prior contents.
REQ-037 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 until the handshake.
REQ-038 Reset during WAIT of a write to 0x40 (WAIT_STATES=2) -> no response, req_ready=1 after release, read of 0x40 returns the old value.
